// File: rtl/rom_reader_pkg.sv
// Shared types and default widths for the ROM dump sequencer and its testbench.
package rom_reader_pkg;

  localparam int unsigned DefaultDataWidth    = 4;
  localparam int unsigned DefaultAddressWidth = 8;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StSettle,
    StCapture,
    StEmit,
    StStep,
    StDone,
    StError
  } seq_state_e;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter; expired flags the last cycle of the settle window.
module settle_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  localparam logic [WIDTH-1:0] One = 1;

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - One;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Count of 1 marks the final settle clock, so a load of N gives exactly N clocks.
  assign expired = (count_q <= One);

endmodule

// File: rtl/rom_dump_sequencer.sv
// Walks a ROM reader through every address, checks the reported address and
// hands each captured address/data pair to a ready/valid consumer.
module rom_dump_sequencer
  import rom_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DefaultDataWidth,
  parameter int unsigned ADDRESS_WIDTH = DefaultAddressWidth,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] address_line,
  input  logic [DATA_WIDTH-1:0]    data_line,
  output logic                     address_clear,
  output logic                     increment_address,
  output logic                     sample_valid,
  input  logic                     sample_ready,
  output logic [ADDRESS_WIDTH-1:0] sample_address,
  output logic [DATA_WIDTH-1:0]    sample_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES);

  seq_state_e state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] expected_q, expected_d;
  logic timer_load, timer_enable, timer_expired, capture;

  logic                     address_clear_q, increment_q, sample_valid_q;
  logic                     busy_q, done_q, error_q;
  logic [ADDRESS_WIDTH-1:0] sample_address_q;
  logic [DATA_WIDTH-1:0]    sample_data_q;

  settle_timer #(
    .WIDTH (8)
  ) u_settle_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_value (SettleLoad),
    .enable     (timer_enable),
    .expired    (timer_expired)
  );

  always_comb begin
    state_d      = state_q;
    expected_d   = expected_q;
    timer_load   = 1'b0;
    timer_enable = 1'b0;
    capture      = 1'b0;
    case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d    = StClear;
          expected_d = '0;
        end
      end
      StClear: begin
        timer_load = 1'b1;
        state_d    = StSettle;
      end
      StSettle: begin
        timer_enable = 1'b1;
        if (timer_expired) state_d = StCapture;
      end
      StCapture: begin
        capture = 1'b1;
        state_d = (address_line == expected_q) ? StEmit : StError;
      end
      StEmit: begin
        // sample_valid is high throughout EMIT, so ready alone completes the handshake.
        if (sample_ready) state_d = (expected_q == '1) ? StDone : StStep;
      end
      StStep: begin
        expected_d = expected_q + 1'b1;
        timer_load = 1'b1;
        state_d    = StSettle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StIdle;
      expected_q       <= '0;
      address_clear_q  <= 1'b0;
      increment_q      <= 1'b0;
      sample_valid_q   <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
      sample_address_q <= '0;
      sample_data_q    <= '0;
    end else begin
      state_q         <= state_d;
      expected_q      <= expected_d;
      // Flags are decoded from the next state so they line up with the state register.
      address_clear_q <= (state_d == StClear);
      increment_q     <= (state_d == StStep);
      sample_valid_q  <= (state_d == StEmit);
      busy_q          <= (state_d inside {StClear, StSettle, StCapture, StEmit, StStep});
      done_q          <= (state_d == StDone);
      error_q         <= (state_d == StError);
      if (capture) begin
        sample_address_q <= address_line;
        sample_data_q    <= data_line;
      end
    end
  end

  assign address_clear     = address_clear_q;
  assign increment_address = increment_q;
  assign sample_valid      = sample_valid_q;
  assign sample_address    = sample_address_q;
  assign sample_data       = sample_data_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = error_q;

endmodule

// File: tb/tb_rom_dump_sequencer.sv
// Bench for rom_dump_sequencer: model ROM reader, full dumps, backpressure,
// address skip, mid-dump reset and start-while-busy.
module tb_rom_dump_sequencer;

  localparam int Settle = 4;
  localparam int Words  = 256;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] address_line;
  logic [3:0] data_line;
  logic       address_clear, increment_address, sample_valid, sample_ready;
  logic [7:0] sample_address;
  logic [3:0] sample_data;
  logic       busy, done, error;

  logic [7:0] rd_addr;
  logic       skip_en;

  int checks = 0;
  int errors = 0;

  logic [7:0] log_addr [0:1023];
  logic [3:0] log_data [0:1023];
  int log_n   = 0;
  int clr_cnt = 0;
  int inc_cnt = 0;
  int bad_pulse_cnt = 0;

  typedef struct {
    int         idx;
    logic [7:0] addr;
    logic [3:0] data;
  } vec_t;
  vec_t vecs [9];

  always #5 clk = ~clk;

  rom_dump_sequencer #(
    .DATA_WIDTH    (4),
    .ADDRESS_WIDTH (8),
    .SETTLE_CYCLES (Settle)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .address_line      (address_line),
    .data_line         (data_line),
    .address_clear     (address_clear),
    .increment_address (increment_address),
    .sample_valid      (sample_valid),
    .sample_ready      (sample_ready),
    .sample_address    (sample_address),
    .sample_data       (sample_data),
    .busy              (busy),
    .done              (done),
    .error             (error)
  );

  // Model reader: follows the pulses, optionally skipping 0x10.
  always_ff @(posedge clk) begin
    if (address_clear) rd_addr <= 8'h00;
    else if (increment_address) rd_addr <= (skip_en && rd_addr == 8'h0F) ? 8'h11 : rd_addr + 8'h01;
  end

  assign address_line = rd_addr;
  assign data_line    = rd_addr[3:0] ^ rd_addr[7:4] ^ 4'h6;

  function automatic logic [3:0] model_data(input logic [7:0] a);
    return a[3:0] ^ a[7:4] ^ 4'h6;
  endfunction

  always @(negedge clk) begin
    if (sample_valid && sample_ready && log_n < 1024) begin
      log_addr[log_n] = sample_address;
      log_data[log_n] = sample_data;
      log_n++;
    end
    if (address_clear) clr_cnt++;
    if (increment_address) inc_cnt++;
    if ((address_clear && increment_address) || ((address_clear || increment_address) && !busy))
      bad_pulse_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return {18'd0, address_clear, increment_address, sample_valid, busy, done, error,
            sample_address, sample_data};
  endfunction

  // Counts log entries of one dump that differ from the expected address order / model data.
  function automatic int dump_order_bad(input int base, input int count);
    int bad = 0;
    for (int i = 0; i < count; i++) begin
      if (log_addr[base+i] !== 8'(i) || log_data[base+i] !== model_data(8'(i))) bad++;
    end
    return bad;
  endfunction

  task automatic do_dump(input int bp_addr, input int busy_addr, output int cycles);
    int   bp_left = 0;
    bit   bp_done = 0;
    bit   busy_done = 0;
    int   bp_bad = 0;
    int   inc_at_bp = 0;
    int   clr_at_busy = 0;
    logic [7:0] hold_a = 0;
    logic [3:0] hold_d = 0;
    @(posedge clk); #1;
    start = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
      start = 1'b0;
      if (cycles == 1) check("start_clears_status", {29'd0, done, error, busy}, 32'h1);
      if (bp_left > 0) begin
        if (!sample_valid || sample_address !== hold_a || sample_data !== hold_d) bp_bad++;
        bp_left--;
        if (bp_left == 0) begin
          sample_ready = 1'b1;
          check("bp_sample_stable", bp_bad, 0);
          check("bp_no_increment", inc_cnt - inc_at_bp, 0);
        end
      end else if (!bp_done && sample_valid && int'(sample_address) == bp_addr) begin
        sample_ready = 1'b0;
        bp_left = 10;
        bp_done = 1;
        hold_a = sample_address;
        hold_d = sample_data;
        inc_at_bp = inc_cnt;
      end
      if (!busy_done && sample_valid && int'(sample_address) == busy_addr) begin
        start = 1'b1;
        busy_done = 1;
        clr_at_busy = clr_cnt;
      end
    end while (!done && !error && cycles < 6000);
    if (cycles >= 6000) begin
      checks++;
      errors++;
      $display("FAIL dump_timeout: got %0d cycles without done/error, required fewer than 6000",
               cycles);
    end
    if (busy_done) check("start_while_busy_no_clear", clr_cnt - clr_at_busy, 0);
    cycles = cycles - 1;
  endtask

  initial begin
    int cyc, base_a, base_b, base_e, base_r, c0, i0, n, zero_bad;
    vecs[0] = '{idx: 0,    addr: 8'h00, data: 4'h6};
    vecs[1] = '{idx: 1,    addr: 8'h01, data: 4'h7};
    vecs[2] = '{idx: 5,    addr: 8'h05, data: 4'h3};
    vecs[3] = '{idx: 32,   addr: 8'h20, data: 4'h4};
    vecs[4] = '{idx: 55,   addr: 8'h37, data: 4'h2};
    vecs[5] = '{idx: 90,   addr: 8'h5A, data: 4'h9};
    vecs[6] = '{idx: 128,  addr: 8'h80, data: 4'hE};
    vecs[7] = '{idx: 195,  addr: 8'hC3, data: 4'h9};
    vecs[8] = '{idx: 255,  addr: 8'hFF, data: 4'h6};

    reset_n = 1'b0;
    start = 1'b0;
    sample_ready = 1'b1;
    skip_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outputs(), 0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_outputs", all_outputs(), 0);

    // Dump A: ready tied high, timing and ordering.
    base_a = log_n; c0 = clr_cnt; i0 = inc_cnt;
    do_dump(-1, -1, cyc);
    checks++;
    if (cyc < Words * (Settle + 3) - 2 || cyc > Words * (Settle + 3) + 2) begin
      errors++;
      $display("FAIL dump_cycles: got %0d expected %0d +-2", cyc, Words * (Settle + 3));
    end
    check("a_status", {29'd0, done, error, busy}, 32'h4);
    check("a_count", log_n - base_a, Words);
    check("a_order", dump_order_bad(base_a, Words), 0);
    check("a_clears", clr_cnt - c0, 1);
    check("a_increments", inc_cnt - i0, Words - 1);
    for (int v = 0; v < 9; v++) begin
      check($sformatf("a_vec%0d_addr", v), log_addr[base_a + vecs[v].idx], vecs[v].addr);
      check($sformatf("a_vec%0d_data", v), log_data[base_a + vecs[v].idx], vecs[v].data);
    end

    // Dump B from DONE: backpressure at 0x05, start pulse while busy at 0x20.
    base_b = log_n; c0 = clr_cnt; i0 = inc_cnt;
    do_dump(5, 32, cyc);
    check("b_status", {29'd0, done, error, busy}, 32'h4);
    check("b_count", log_n - base_b, Words);
    n = 0;
    for (int i = 0; i < Words; i++)
      if (log_addr[base_b+i] !== log_addr[base_a+i] || log_data[base_b+i] !== log_data[base_a+i])
        n++;
    check("b_matches_a", n, 0);
    check("b_clears", clr_cnt - c0, 1);
    check("b_increments", inc_cnt - i0, Words - 1);

    // Reader skips 0x10.
    skip_en = 1'b1;
    base_e = log_n; c0 = clr_cnt; i0 = inc_cnt;
    do_dump(-1, -1, cyc);
    check("skip_status", {29'd0, done, error, busy}, 32'h2);
    check("skip_sample_address", sample_address, 8'h11);
    check("skip_sample_data", sample_data, 4'h6);
    check("skip_sample_valid", sample_valid, 0);
    check("skip_count", log_n - base_e, 16);
    check("skip_order", dump_order_bad(base_e, 16), 0);
    check("skip_increments", inc_cnt - i0, 16);
    c0 = clr_cnt; i0 = inc_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("skip_no_more_pulses", (clr_cnt - c0) + (inc_cnt - i0), 0);
    check("skip_error_held", {29'd0, done, error, busy}, 32'h2);

    // Reset in the middle of a dump at 0x40.
    skip_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(sample_valid && sample_address == 8'h40) && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 4000) begin
      checks++;
      errors++;
      $display("FAIL reach_0x40_timeout: got %0d cycles, required fewer than 4000", n);
    end
    reset_n = 1'b0;
    #1;
    check("midreset_outputs_now", all_outputs(), 0);
    c0 = clr_cnt; i0 = inc_cnt; zero_bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (all_outputs() != 0) zero_bad++;
    end
    check("midreset_outputs_held", zero_bad, 0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("midreset_no_pulses", (clr_cnt - c0) + (inc_cnt - i0), 0);
    check("midreset_idle", all_outputs(), 0);
    base_r = log_n; c0 = clr_cnt;
    do_dump(-1, -1, cyc);
    check("restart_clears", clr_cnt - c0, 1);
    check("restart_count", log_n - base_r, Words);
    check("restart_order", dump_order_bad(base_r, Words), 0);
    check("restart_done", {29'd0, done, error, busy}, 32'h4);

    check("pulse_rules", bad_pulse_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_dump_sequencer.md
ROM_DUMP_SEQUENCER -- requirements
Module: rom_dump_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, ROM data word width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 8, ROM address width; dump length 2^ADDRESS_WIDTH words.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4, clocks from address change to data sample; legal range 1..255.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  level; sampled high in IDLE, DONE or ERROR begins a dump.
REQ-007 SHALL have port address_line  in  ADDRESS_WIDTH  current address reported by the reader stage.
REQ-008 SHALL have port data_line  in  DATA_WIDTH  data word reported by the reader stage.
REQ-009 SHALL have port address_clear  out  1  one-cycle pulse forcing the reader address to 0.
REQ-010 SHALL have port increment_address  out  1  one-cycle pulse stepping the reader address by +1.
REQ-011 SHALL have port sample_valid  out  1  sample_address/sample_data hold a captured word.
REQ-012 SHALL have port sample_ready  in  1  consumer accepts the sample when high with sample_valid.
REQ-013 SHALL have ports sample_address  out  ADDRESS_WIDTH and sample_data  out  DATA_WIDTH  captured pair.
REQ-014 SHALL have ports busy, done, error  out  1 each  status flags.

Function
REQ-015 SHALL implement FSM states IDLE, CLEAR, SETTLE, CAPTURE, EMIT, STEP, DONE, ERROR.
REQ-016 IDLE/DONE/ERROR with start=1 SHALL go to CLEAR; expected-address counter loads 0; done and error clear.
REQ-017 CLEAR SHALL assert address_clear for exactly one cycle, then go to SETTLE.
REQ-018 SETTLE SHALL count SETTLE_CYCLES clocks, then go to CAPTURE.
REQ-019 CAPTURE SHALL, in one cycle, register address_line and data_line into sample_address/sample_data; if address_line != expected address go to ERROR, else to EMIT.
REQ-020 EMIT SHALL hold sample_valid=1 and sample registers stable until sample_valid && sample_ready; no timeout.
REQ-021 On handshake with expected address = 2^ADDRESS_WIDTH-1, SHALL go to DONE; otherwise go to STEP.
REQ-022 STEP SHALL assert increment_address for exactly one cycle, increment expected address, then go to SETTLE.
REQ-023 Expected-address counter SHALL be ADDRESS_WIDTH bits; it never wraps within a dump (DONE precedes overflow).
REQ-024 busy SHALL be 1 in CLEAR, SETTLE, CAPTURE, EMIT, STEP; 0 otherwise.
REQ-025 done SHALL be 1 in DONE; error SHALL be 1 in ERROR; both held until next start or reset.
REQ-026 start while busy SHALL be ignored.
REQ-027 address_clear and increment_address SHALL never be asserted in the same cycle, and never outside CLEAR/STEP.
REQ-028 Minimum per-word period with sample_ready tied high SHALL be SETTLE_CYCLES+3 clocks.

Reset
REQ-029 reset_n low SHALL asynchronously force IDLE, expected address 0, settle counter 0.
REQ-030 During and after reset all outputs SHALL be 0 (sample_address, sample_data included).
REQ-031 Reset mid-dump SHALL abort it with no further pulses; a new start re-dumps from address 0.

Structure
REQ-032 Package rom_reader_pkg SHALL hold the FSM state enum and default DATA_WIDTH/ADDRESS_WIDTH constants.
REQ-033 Settle counting SHALL be a sub-module settle_timer (load, count-down, expired output).
REQ-034 Output pulses and flags SHALL be registered (no combinational path from inputs to outputs).

Verification
REQ-035 Full dump, model reader tracks pulses, sample_ready=1: 256 samples, addresses 0..255 in order, data matches model, done=1, 256 clocks x (SETTLE_CYCLES+3) ±2.
REQ-036 Backpressure: sample_ready low 10 clocks at address 0x05 -> sample held stable, no increment_address pulse until accepted.
REQ-037 Model reader skips an address at 0x10 -> error=1 with sample_address=0x11, busy=0, no further pulses.
REQ-038 reset_n low at address 0x40 for 3 clocks -> all outputs 0 immediately; start -> address_clear pulse, dump restarts at 0.
REQ-039 start pulsed while busy at address 0x20 -> no address_clear, sequence uninterrupted.
REQ-040 start in DONE -> done clears, one address_clear pulse, second full dump identical to first.
